// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: default widths, FSM encoding
// and the byte-enable mask helper.
package fifo_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int PACK_DEF      = 4;

  typedef logic [1:0] state_t;
  localparam state_t RUN        = 2'd0;
  localparam state_t FLUSH_WAIT = 2'd1;
  localparam state_t FLUSH_EMIT = 2'd2;

  // Mask with the low n bits set; callers truncate to their own width.
  function automatic logic [31:0] keep_mask(input int unsigned n);
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed-word stream; master is the packer, slave is the environment.
interface fifo_rd_packer_if
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int PACK      = PACK_DEF
) ();

  logic [DATA_SIZE-1:0]      fifo_rd_data;
  logic                      fifo_rempty;
  logic                      fifo_rd_en;
  logic                      flush;
  logic [DATA_SIZE*PACK-1:0] out_data;
  logic [PACK-1:0]           out_keep;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;
  logic                      flush_done;

  modport master (
    input  fifo_rd_data, fifo_rempty, flush, out_ready,
    output fifo_rd_en, out_data, out_keep, out_last, out_valid, flush_done
  );

  modport slave (
    output fifo_rd_data, fifo_rempty, flush, out_ready,
    input  fifo_rd_en, out_data, out_keep, out_last, out_valid, flush_done
  );

endinterface

// File: rtl/fifo_rd_packer.sv
// Packs PACK consecutive FIFO entries into one word on a valid/ready stream;
// a flush drains a partial word with byte-enables and a last marker.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int PACK      = PACK_DEF
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  fifo_rd_packer_if.master  bus
);

  localparam int IW = $clog2(PACK);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] PACK_CNT  = CW'(PACK);
  localparam logic [CW:0]   PACK_FILL = (CW+1)'(PACK);

  state_t                          state;
  logic [CW-1:0]                   cnt;
  logic                            pend;
  logic [PACK-1:0][DATA_SIZE-1:0]  acc;
  logic [PACK-1:0][DATA_SIZE-1:0]  acc_masked;
  logic [PACK-1:0]                 cnt_keep;
  logic [CW:0]                     fill;
  logic                            slot_free;
  logic                            rd_issue;

  // Count the in-flight byte so the accumulator can never be overfilled.
  assign fill      = {1'b0, cnt} + {{CW{1'b0}}, pend};
  assign rd_issue  = ~bus.fifo_rempty & (state == RUN) & (fill < PACK_FILL);
  assign slot_free = ~bus.out_valid | bus.out_ready;
  assign cnt_keep  = PACK'(keep_mask(32'(cnt)));

  assign bus.fifo_rd_en = rd_issue;

  always_comb begin
    acc_masked = '0;
    for (int i = 0; i < PACK; i++) begin
      if (cnt_keep[i]) acc_masked[i] = acc[i];
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state          <= RUN;
      cnt            <= '0;
      pend           <= 1'b0;
      acc            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_keep   <= '0;
      bus.out_last   <= 1'b0;
      bus.flush_done <= 1'b0;
    end else begin
      pend           <= rd_issue;
      bus.flush_done <= 1'b0;

      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      // Landing never coincides with a load: loads need cnt==PACK or pend==0.
      if (pend) begin
        acc[cnt[IW-1:0]] <= bus.fifo_rd_data;
        cnt              <= cnt + CW'(1);
      end

      case (state)
        RUN: begin
          if (cnt == PACK_CNT && slot_free) begin
            bus.out_data  <= acc;
            bus.out_keep  <= '1;
            bus.out_last  <= 1'b0;
            bus.out_valid <= 1'b1;
            cnt           <= '0;
          end
          if (bus.flush) state <= FLUSH_WAIT;
        end

        FLUSH_WAIT: begin
          if (!pend) begin
            if (cnt == '0) begin
              bus.flush_done <= 1'b1;
              state          <= RUN;
            end else begin
              state <= FLUSH_EMIT;
            end
          end
        end

        FLUSH_EMIT: begin
          if (slot_free) begin
            bus.out_data   <= acc_masked;
            bus.out_keep   <= cnt_keep;
            bus.out_last   <= 1'b1;
            bus.out_valid  <= 1'b1;
            bus.flush_done <= 1'b1;
            cnt            <= '0;
            state          <= RUN;
          end
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: byte-level packing model, FIFO model, output monitor.
module tb_fifo_rd_packer;

  localparam int DS = 8;
  localparam int PK = 4;

  typedef struct {
    logic [DS*PK-1:0] data;
    logic [PK-1:0]    keep;
    logic             last;
  } word_t;

  logic rd_clk = 1'b0;
  logic rd_rst;

  int checks = 0;
  int errors = 0;
  int exp_flush = 0;
  int obs_flush = 0;

  word_t      exp_q[$];
  logic [7:0] partial[$];
  logic [7:0] in_q[$];
  logic [7:0] fq[$];

  fifo_rd_packer_if #(.DATA_SIZE(DS), .PACK(PK)) bus ();

  fifo_rd_packer #(.DATA_SIZE(DS), .PACK(PK)) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (bus)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: one-cycle read latency, writes become visible at the next edge.
  always @(posedge rd_clk) begin
    if (bus.fifo_rd_en === 1'b1 && bus.fifo_rempty === 1'b0 && fq.size() > 0)
      bus.fifo_rd_data <= fq.pop_front();
    while (in_q.size() > 0) fq.push_back(in_q.pop_front());
    bus.fifo_rempty <= (fq.size() == 0);
  end

  // Output monitor: every cycle a word is presented it must match the queue head.
  always @(negedge rd_clk) begin
    if (rd_rst === 1'b0) begin
      if (bus.fifo_rempty === 1'b1) check("rd_en_while_empty", {63'd0, bus.fifo_rd_en}, 64'd0);
      if (bus.flush_done === 1'b1) obs_flush++;
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data %0h keep %0h last %0b, no word expected",
                   bus.out_data, bus.out_keep, bus.out_last);
        end else begin
          check("word_data", {32'd0, bus.out_data}, {32'd0, exp_q[0].data});
          check("word_keep", {60'd0, bus.out_keep}, {60'd0, exp_q[0].keep});
          check("word_last", {63'd0, bus.out_last}, {63'd0, exp_q[0].last});
          if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic emit_partial(input logic last);
    word_t w;
    w.data = '0;
    for (int i = 0; i < partial.size(); i++) w.data[i*DS +: DS] = partial[i];
    w.keep = PK'((1 << partial.size()) - 1);
    w.last = last;
    exp_q.push_back(w);
    partial.delete();
  endtask

  task automatic push(input logic [7:0] b);
    in_q.push_back(b);
    partial.push_back(b);
    if (partial.size() == PK) emit_partial(1'b0);
  endtask

  task automatic settle();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while ((in_q.size() > 0 || fq.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL settle_timeout: FIFO still holds %0d bytes", fq.size() + in_q.size());
    end
    repeat (2*PK + 6) tick();
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_flush(output int lat);
    exp_flush++;
    if (partial.size() > 0) emit_partial(1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    lat = 0;
    while (bus.flush_done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check("flush_done_seen", {63'd0, (lat < 10)}, 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    rd_rst        = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    check("rst_out_keep", {60'd0, bus.out_keep}, 64'd0);
    check("rst_out_last", {63'd0, bus.out_last}, 64'd0);
    check("rst_flush_done", {63'd0, bus.flush_done}, 64'd0);
    check("rst_rd_en", {63'd0, bus.fifo_rd_en}, 64'd0);
    rd_rst = 1'b0;
    tick();

    // Basic pack.
    bus.out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    settle();
    check("basic_rd_en_idle", {63'd0, bus.fifo_rd_en}, 64'd0);

    // Back-pressure with three words queued behind a stalled output.
    bus.out_ready = 1'b0;
    for (int b = 1; b <= 12; b++) push(8'(b));
    repeat (20) tick();
    check("bp_valid_held", {63'd0, bus.out_valid}, 64'd1);
    check("bp_word_held", {32'd0, bus.out_data}, 64'h04030201);
    check("bp_rd_en_stalled", {63'd0, bus.fifo_rd_en}, 64'd0);
    settle();

    // Partial flush.
    push(8'hAA); push(8'hBB);
    settle();
    do_flush(lat);
    check("pflush_data", {32'd0, bus.out_data}, 64'h0000BBAA);
    check("pflush_keep", {60'd0, bus.out_keep}, 64'h3);
    check("pflush_last", {63'd0, bus.out_last}, 64'd1);
    tick();
    check("pflush_done_pulse", {63'd0, bus.flush_done}, 64'd0);
    settle();

    // Flush in the same cycle the third read is issued.
    push(8'hAA); push(8'hBB);
    settle();
    push(8'hCC);
    tick();
    check("inflight_rd_issue", {63'd0, bus.fifo_rd_en}, 64'd1);
    do_flush(lat);
    check("inflight_data", {32'd0, bus.out_data}, 64'h00CCBBAA);
    check("inflight_keep", {60'd0, bus.out_keep}, 64'h7);
    settle();

    // Empty flush.
    do_flush(lat);
    check("empty_flush_latency", {63'd0, (lat <= 2)}, 64'd1);
    check("empty_flush_no_word", {63'd0, bus.out_valid}, 64'd0);
    settle();

    // Asynchronous reset with a held word and two bytes in the accumulator.
    bus.out_ready = 1'b0;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    push(8'h61); push(8'h62);
    repeat (12) tick();
    #2;
    rd_rst = 1'b1;
    exp_q.delete();
    partial.delete();
    #1;
    check("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("arst_out_data", {32'd0, bus.out_data}, 64'd0);
    check("arst_out_keep", {60'd0, bus.out_keep}, 64'd0);
    check("arst_rd_en", {63'd0, bus.fifo_rd_en}, 64'd0);
    repeat (2) tick();
    rd_rst = 1'b0;
    bus.out_ready = 1'b1;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    settle();

    // Randomised traffic with random back-pressure and occasional flushes.
    for (int it = 0; it < 60; it++) begin
      int nb;
      nb = $urandom_range(1, 9);
      for (int k = 0; k < nb; k++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        push(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) tick();
      end
      repeat ($urandom_range(0, 6)) begin
        bus.out_ready = ($urandom_range(0, 1) != 0);
        tick();
      end
      if ($urandom_range(0, 3) == 0) begin
        settle();
        do_flush(lat);
      end
    end
    settle();
    do_flush(lat);
    settle();
    check("flush_count", 64'(obs_flush), 64'(exp_flush));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
